ecc_mem_ctrl: RTL

- Front-end controller for the 256x4 Hamming(7,4) ECC memory.
- Arbitrates two host requesters onto the single memory port, round-robin.
- Runs a background scrubber: walks every address, reads it, and writes corrected data back when an error is detected.
- Exports per-read error status and scrub statistics to the CSR layer.

---
 rtl/ecc_ctrl_pkg.sv | 14 +
 rtl/ecc_rr_arb.sv | 33 +++
 rtl/ecc_mem_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ecc_ctrl_pkg.sv
// Shared types and constants for the ECC memory front-end controller.
// Imported by the arbiter and the controller top.
package ecc_ctrl_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 4;
  localparam int SCNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    HRD_WAIT,
    SRD_WAIT,
    SWB
  } state_e;
endpackage

// File: rtl/ecc_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves past the winner
// whenever the grant is actually consumed (advance).
module ecc_rr_arb
  import ecc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       idx
);

  logic ptr_q, ptr_d;

  // Winner selection: pointer breaks ties, lone requester always wins.
  always_comb begin
    idx   = 1'b0;
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (req == 2'b11) idx = ptr_q;
    else              idx = req[1];
    if (|req)         gnt = idx ? 2'b10 : 2'b01;
    if (advance)      ptr_d = ~idx;
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ecc_mem_ctrl.sv
// Host arbitration plus background scrubber for the Hamming(7,4) memory.
// Scrub logic is built only when ECC_SCRUB_EN is defined.
module ecc_mem_ctrl
  import ecc_ctrl_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int STARVE_LIMIT   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          h_req,
  input  logic [1:0]          h_we,
  input  logic [2*ADDR_W-1:0] h_addr,
  input  logic [2*DATA_W-1:0] h_wdata,
  output logic [1:0]          h_gnt,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err_det,
  output logic                rsp_err_corr,
  input  logic                scrub_en,
  output logic [SCNT_W-1:0]   scrub_corr_cnt,
  output logic                scrub_pass_done,
  output logic                mem_en,
  output logic                mem_wr_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_err_det,
  input  logic                mem_err_corr
);

  state_e state_q, state_d;
  logic   rid_q;
  logic   win;
  logic [1:0] arb_gnt;
  logic   host_go, scrub_go, scrub_done, scrub_wb;
  logic   scrub_win;
  logic [ADDR_W-1:0] sptr;
  logic [DATA_W-1:0] sdata;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign win_addr  = win ? h_addr[2*ADDR_W-1:ADDR_W]
                         : h_addr[ADDR_W-1:0];
  assign win_wdata = win ? h_wdata[2*DATA_W-1:DATA_W]
                         : h_wdata[DATA_W-1:0];

  ecc_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (h_req),
    .advance (host_go),
    .gnt     (arb_gnt),
    .idx     (win)
  );

  // Next state, memory strobes and host-facing outputs.
  always_comb begin
    state_d    = state_q;
    h_gnt      = 2'b00;
    rsp_valid  = 1'b0;
    mem_en     = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    host_go    = 1'b0;
    scrub_go   = 1'b0;
    scrub_done = 1'b0;
    scrub_wb   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (scrub_win) begin
          scrub_go = 1'b1;
          mem_en   = 1'b1;
          mem_addr = sptr;
          state_d  = SRD_WAIT;
        end else if (|h_req) begin
          host_go   = 1'b1;
          h_gnt     = arb_gnt;
          mem_en    = 1'b1;
          mem_wr_en = h_we[win];
          mem_addr  = win_addr;
          mem_wdata = win_wdata;
          if (!h_we[win]) state_d = HRD_WAIT;
        end
      end
      HRD_WAIT: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      SRD_WAIT: begin
        if (mem_err_det) begin
          state_d = SWB;
        end else begin
          scrub_done = 1'b1;
          state_d    = IDLE;
        end
      end
      SWB: begin
        mem_en     = 1'b1;
        mem_wr_en  = 1'b1;
        mem_addr   = sptr;
        mem_wdata  = sdata;
        scrub_wb   = 1'b1;
        scrub_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_id       = rid_q;
  assign rsp_data     = rsp_valid ? mem_rdata : '0;
  assign rsp_err_det  = rsp_valid & mem_err_det;
  assign rsp_err_corr = rsp_valid & mem_err_corr;

  // FSM state and owner of the outstanding host read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (host_go && !h_we[win]) rid_q <= win;
    end
  end

`ifdef ECC_SCRUB_EN
  localparam int TW = $clog2(SCRUB_INTERVAL);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0] sptr_q;
  logic [DATA_W-1:0] sdata_q;
  logic [TW-1:0]     timer_q;
  logic [SW-1:0]     starve_q;
  logic              pend_q;
  logic [SCNT_W-1:0] cnt_q;

  assign scrub_win = pend_q &
    (~|h_req | (starve_q >= SW'(STARVE_LIMIT)));
  assign sptr  = sptr_q;
  assign sdata = sdata_q;
  assign scrub_corr_cnt  = cnt_q;
  assign scrub_pass_done = scrub_done & (&sptr_q);

  // Scrub pointer, interval timer, starvation and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sptr_q   <= '0;
      sdata_q  <= '0;
      timer_q  <= '0;
      starve_q <= '0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (state_q == SRD_WAIT) sdata_q <= mem_rdata;
      if (scrub_go) begin
        starve_q <= '0;
      end else if (state_q == IDLE && pend_q) begin
        starve_q <= starve_q + SW'(1);
      end
      if (!scrub_en) begin
        timer_q <= '0;
      end else if (!pend_q) begin
        if (timer_q == TW'(SCRUB_INTERVAL - 1)) begin
          timer_q <= '0;
          pend_q  <= 1'b1;
        end else begin
          timer_q <= timer_q + TW'(1);
        end
      end
      if (scrub_done) begin
        sptr_q <= sptr_q + ADDR_W'(1);
        pend_q <= 1'b0;
      end
      if (scrub_wb && cnt_q != '1) cnt_q <= cnt_q + SCNT_W'(1);
    end
  end
`else
  logic unused_scrub;

  assign scrub_win       = 1'b0;
  assign sptr            = '0;
  assign sdata           = '0;
  assign scrub_corr_cnt  = '0;
  assign scrub_pass_done = 1'b0;
  assign unused_scrub    = ^{scrub_en, scrub_go, scrub_done,
                             scrub_wb, SCRUB_INTERVAL > 1,
                             STARVE_LIMIT > 0};
`endif

endmodule
